// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: state encoding and 48 MHz / 10 MHz defaults for clk_lock_monitor
package clk_mon_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    MEASURE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;
  localparam int DEF_SETTLE_CYCLES = 4800;
  localparam int DEF_WINDOW        = 4800;
  localparam int DEF_ENC_MIN       = 990;
  localparam int DEF_ENC_MAX       = 1010;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: N-flop single-bit synchroniser with optional rising-edge detect
module cdc_sync_bit #(
  parameter int N    = 2,
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);
  logic [N-1:0] s_q;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) s_q <= '0;
    else s_q <= {s_q[N-2:0], d_i};
  assign q_o    = s_q[N-1];
  assign rise_o = EDGE ? s_q[N-2] & ~s_q[N-1] : 1'b0;
endmodule

// File: rtl/clk_lock_monitor.sv
// clk_lock_monitor: gates ADC readout reset on DCM lock and ADC_ENC frequency check
module clk_lock_monitor
  import clk_mon_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW        = DEF_WINDOW,
  parameter int ENC_MIN       = DEF_ENC_MIN,
  parameter int ENC_MAX       = DEF_ENC_MAX,
  parameter int CNT_W         = 16
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  input  logic             LOCKED,
  input  logic             ADC_ENC,
  input  logic             CLR_CNT,
  output logic             ADC_RST,
  output logic             CLK_OK,
  output logic [15:0]      ENC_COUNT,
  output logic [CNT_W-1:0] LOSS_COUNT,
  output logic [2:0]       STATE
);
  localparam int TMAX = SETTLE_CYCLES > WINDOW ? SETTLE_CYCLES : WINDOW;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);
  localparam logic [15:0] EMIN = 16'(ENC_MIN);
  localparam logic [15:0] EMAX = 16'(ENC_MAX);
  logic lk_s, enc_edge, lk_rise_unused;
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] edges_q, edges_d, edges_inc, enc_q, enc_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic adc_rst_q, clk_ok_q, win, win_end, in_range, lock_loss;
  cdc_sync_bit #(.N(2), .EDGE(1'b0)) u_lock_sync (
    .clk_i(BUS_CLK), .rst_i(BUS_RST), .d_i(LOCKED), .q_o(lk_s), .rise_o(lk_rise_unused)
  );
  logic enc_q_unused;
  cdc_sync_bit #(.N(3), .EDGE(1'b1)) u_enc_sync (
    .clk_i(BUS_CLK), .rst_i(BUS_RST), .d_i(ADC_ENC), .q_o(enc_q_unused), .rise_o(enc_edge)
  );
  // next state, window timing, edge counting and lock-loss bookkeeping
  always_comb begin
    win       = state_q inside {MEASURE, RUN, FAULT};
    win_end   = win && timer_q == WIN_LAST;
    edges_inc = edges_q == '1 ? edges_q : edges_q + 16'(enc_edge);
    in_range  = edges_inc >= EMIN && edges_inc <= EMAX;
    lock_loss = state_q != WAIT_LOCK && !lk_s;
    state_d   = state_q;
    timer_d   = '0;
    edges_d   = '0;
    enc_d     = win_end ? edges_inc : enc_q;
    if (win) begin
      timer_d = win_end ? '0 : timer_q + TW'(1);
      edges_d = win_end ? '0 : edges_inc;
    end
    unique case (state_q)
      WAIT_LOCK: state_d = lk_s ? SETTLE : WAIT_LOCK;
      SETTLE: begin
        timer_d = timer_q == SETTLE_LAST ? '0 : timer_q + TW'(1);
        state_d = timer_q == SETTLE_LAST ? MEASURE : SETTLE;
      end
      MEASURE: state_d = win_end ? (in_range ? RUN : FAULT) : MEASURE;
      RUN:     state_d = win_end && !in_range ? FAULT : RUN;
      FAULT:   state_d = win_end && in_range ? SETTLE : FAULT;
      default: state_d = WAIT_LOCK;
    endcase
    if (lock_loss) begin
      state_d = WAIT_LOCK;
      timer_d = '0;
      edges_d = '0;
    end
    loss_d = CLR_CNT ? '0 : lock_loss && loss_q != '1 ? loss_q + CNT_W'(1) : loss_q;
  end
  // state, counters and registered outputs
  always_ff @(posedge BUS_CLK or posedge BUS_RST)
    if (BUS_RST) begin
      state_q   <= WAIT_LOCK;
      timer_q   <= '0;
      edges_q   <= '0;
      enc_q     <= '0;
      loss_q    <= '0;
      adc_rst_q <= 1'b1;
      clk_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      edges_q   <= edges_d;
      enc_q     <= enc_d;
      loss_q    <= loss_d;
      adc_rst_q <= state_d != RUN;
      clk_ok_q  <= state_d == RUN;
    end
  assign STATE      = state_q;
  assign ADC_RST    = adc_rst_q;
  assign CLK_OK     = clk_ok_q;
  assign ENC_COUNT  = enc_q;
  assign LOSS_COUNT = loss_q;
endmodule

// File: tb/tb_clk_lock_monitor.sv
// tb_clk_lock_monitor: directed checks of lock-up, frequency fault, lock loss, counters and async reset
module tb_clk_lock_monitor;
  localparam int S = 48;
  localparam int W = 48;
  localparam int CW = 2;
  logic BUS_CLK = 1'b0;
  logic BUS_RST = 1'b1;
  logic LOCKED = 1'b0;
  logic ADC_ENC = 1'b0;
  logic CLR_CNT = 1'b0;
  logic ADC_RST, CLK_OK;
  logic [15:0] ENC_COUNT;
  logic [CW-1:0] LOSS_COUNT;
  logic [2:0] STATE;
  int checks = 0;
  int failures = 0;
  int enc_half = 240;
  clk_lock_monitor #(
    .SETTLE_CYCLES(S), .WINDOW(W), .ENC_MIN(9), .ENC_MAX(11), .CNT_W(CW)
  ) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .LOCKED(LOCKED), .ADC_ENC(ADC_ENC),
    .CLR_CNT(CLR_CNT), .ADC_RST(ADC_RST), .CLK_OK(CLK_OK), .ENC_COUNT(ENC_COUNT),
    .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
  );
  always #50 BUS_CLK = ~BUS_CLK;
  initial begin
    #5;
    forever #(enc_half) ADC_ENC = ~ADC_ENC;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge BUS_CLK);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i = 0;
    while (STATE !== s && i < budget) begin
      cyc(1);
      i++;
    end
    chk(tag, 32'(STATE), 32'(s));
  endtask
  initial begin
    cyc(2);
    chk("rst_state", 32'(STATE), 0);
    chk("rst_adc_rst", 32'(ADC_RST), 1);
    chk("rst_clk_ok", 32'(CLK_OK), 0);
    chk("rst_enc", 32'(ENC_COUNT), 0);
    chk("rst_loss", 32'(LOSS_COUNT), 0);
    BUS_RST = 1'b0;
    LOCKED = 1'b1;
    cyc(2);
    chk("lock_wait", 32'(STATE), 0);
    cyc(1);
    chk("lock_settle", 32'(STATE), 1);
    chk("lock_settle_rst", 32'(ADC_RST), 1);
    cyc(S - 1);
    chk("settle_end", 32'(STATE), 1);
    cyc(1);
    chk("measure", 32'(STATE), 2);
    cyc(W - 1);
    chk("measure_end", 32'(STATE), 2);
    cyc(1);
    chk("run", 32'(STATE), 3);
    chk("run_adc_rst", 32'(ADC_RST), 0);
    chk("run_clk_ok", 32'(CLK_OK), 1);
    chk("run_enc", 32'(ENC_COUNT), 10);
    cyc(W);
    chk("run2_state", 32'(STATE), 3);
    chk("run2_enc", 32'(ENC_COUNT), 10);
    LOCKED = 1'b0;
    cyc(2);
    chk("loss_2edge_rst", 32'(ADC_RST), 0);
    cyc(1);
    chk("loss_3edge_rst", 32'(ADC_RST), 1);
    chk("loss_state", 32'(STATE), 0);
    chk("loss_count1", 32'(LOSS_COUNT), 1);
    chk("loss_clk_ok", 32'(CLK_OK), 0);
    cyc(2);
    LOCKED = 1'b1;
    cyc(3 + S + W);
    chk("relock_run", 32'(STATE), 3);
    LOCKED = 1'b0;
    #40;
    LOCKED = 1'b1;
    cyc(5);
    chk("glitch1_state", 32'(STATE), 3);
    chk("glitch1_loss", 32'(LOSS_COUNT), 1);
    LOCKED = 1'b0;
    cyc(2);
    LOCKED = 1'b1;
    cyc(1);
    chk("glitch2_state", 32'(STATE), 0);
    chk("glitch2_loss", 32'(LOSS_COUNT), 2);
    wait_state(3'd3, S + W + 10, "glitch2_relock");
    for (int k = 0; k < 5; k++) begin
      LOCKED = 1'b0;
      cyc(3);
      LOCKED = 1'b1;
      cyc(4);
    end
    chk("loss_saturate", 32'(LOSS_COUNT), 3);
    LOCKED = 1'b0;
    cyc(2);
    CLR_CNT = 1'b1;
    cyc(1);
    CLR_CNT = 1'b0;
    chk("clr_wins_state", 32'(STATE), 0);
    chk("clr_wins_loss", 32'(LOSS_COUNT), 0);
    LOCKED = 1'b1;
    cyc(4);
    LOCKED = 1'b0;
    cyc(3);
    chk("loss_after_clr", 32'(LOSS_COUNT), 1);
    CLR_CNT = 1'b1;
    cyc(1);
    CLR_CNT = 1'b0;
    chk("clr_alone", 32'(LOSS_COUNT), 0);
    enc_half = 300;
    LOCKED = 1'b1;
    wait_state(3'd2, S + 10, "fault_measure");
    wait_state(3'd4, W + 5, "fault_state");
    chk("fault_enc", 32'(ENC_COUNT), 8);
    chk("fault_adc_rst", 32'(ADC_RST), 1);
    chk("fault_clk_ok", 32'(CLK_OK), 0);
    cyc(W);
    chk("fault_hold", 32'(STATE), 4);
    enc_half = 240;
    wait_state(3'd1, 3 * W, "fault_resettle");
    cyc(S + W);
    chk("fault_recover_run", 32'(STATE), 3);
    chk("fault_recover_enc", 32'(ENC_COUNT), 10);
    LOCKED = 1'b0;
    cyc(3);
    LOCKED = 1'b1;
    cyc(3 + S + 5);
    chk("pre_reset_measure", 32'(STATE), 2);
    #20;
    BUS_RST = 1'b1;
    #10;
    chk("arst_state", 32'(STATE), 0);
    chk("arst_adc_rst", 32'(ADC_RST), 1);
    chk("arst_clk_ok", 32'(CLK_OK), 0);
    chk("arst_enc", 32'(ENC_COUNT), 0);
    chk("arst_loss", 32'(LOSS_COUNT), 0);
    cyc(1);
    BUS_RST = 1'b0;
    cyc(2);
    chk("arst_relock_wait", 32'(STATE), 0);
    cyc(1);
    chk("arst_relock_settle", 32'(STATE), 1);
    cyc(S + W);
    chk("arst_relock_run", 32'(STATE), 3);
    chk("arst_relock_adc_rst", 32'(ADC_RST), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
